// File: rtl/key_pkg.sv
// Shared definitions for the key event controller: event codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_pkg;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_NONE   = 2'd0;
    localparam evt_code_t EVT_SINGLE = 2'd1;
    localparam evt_code_t EVT_DOUBLE = 2'd2;
    localparam evt_code_t EVT_LONG   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_HOLD,
        ST_WAIT2,
        ST_PRESS2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event handshake bundle between the key controller and its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer throttles with evt_ready; producer holds one event.
// Signals: evt_valid/evt_code/evt_overrun from producer, evt_ready from consumer.
interface key_event_ctrl_if;
    import key_pkg::*;

    logic      evt_valid;
    evt_code_t evt_code;
    logic      evt_ready;
    logic      evt_overrun;

    modport master (output evt_valid, output evt_code, output evt_overrun, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_code, input  evt_overrun, output evt_ready);

endinterface

// File: rtl/key_filter.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low key.
// Latency: key_level follows a clean raw edge after DEB_CYC + 2 cycles.
// Backpressure: none; free-running filter.
// Ports: clk, rst (async active-low), key (raw pin), key_level (debounced, 1 = released).
module key_filter #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_level
);

    localparam int              CW      = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]   CNT_END = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreement (a bounce back) restarts it from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            key_level <= 1'b1;
            cnt       <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_END) begin
                key_level <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounces a push-button and classifies gestures as single, double or long press.
// Latency: event valid 1 cycle after the classifying condition.
// Backpressure: one-entry buffer; new events while full and not taken are dropped (sticky overrun).
// Ports: clk, rst (async active-low), key (raw pin), key_level (debounced), evt (master event handshake).
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int DEB_CYC    = 1_000_000,
    parameter int LONG_CYC   = 50_000_000,
    parameter int DCLICK_CYC = 15_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key,
    output logic                    key_level,
    key_event_ctrl_if.master        evt
);

    localparam int            CW       = $clog2(max_int(LONG_CYC, DCLICK_CYC)) + 1;
    // cnt holds the number of completed cycles in the current state, so the
    // Nth cycle since entering is the one where cnt == N-1.
    localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] DCLK_END = CW'(DCLICK_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          emit;
    evt_code_t     emit_code;

    logic          valid_q;
    evt_code_t     code_q;
    logic          overrun_q;
    logic          hs;
    logic          drop;

    key_filter #(.DEB_CYC(DEB_CYC)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_level (key_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Press/release are taken from the debounced level directly: every state
    // is only ever entered with the level opposite to the one it waits for.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_code = EVT_NONE;
        case (state)
            ST_IDLE: begin
                if (!key_level) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (key_level) begin
                    state_nxt = ST_WAIT2;
                end else if (cnt == LONG_END) begin
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (key_level) state_nxt = ST_IDLE;
            end
            ST_WAIT2: begin
                // A press on the timeout cycle still counts as a double click.
                if (!key_level) begin
                    state_nxt = ST_PRESS2;
                end else if (cnt == DCLK_END) begin
                    emit      = 1'b1;
                    emit_code = EVT_SINGLE;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (key_level) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hs   = valid_q & evt.evt_ready;
    assign drop = emit & valid_q & ~hs;

    // A taken entry frees the slot in the same cycle, so a coincident
    // emission replaces it without counting as an overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            code_q    <= EVT_NONE;
            overrun_q <= 1'b0;
        end else begin
            if (emit && (!valid_q || hs)) begin
                valid_q <= 1'b1;
                code_q  <= emit_code;
            end else if (hs) begin
                valid_q <= 1'b0;
                code_q  <= EVT_NONE;
            end
            overrun_q <= drop | (overrun_q & ~hs);
        end
    end

    assign evt.evt_valid   = valid_q;
    assign evt.evt_code    = code_q;
    assign evt.evt_overrun = overrun_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
module tb_key_event_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key = 1'b1;
    logic ready = 1'b1;
    logic key_level;

    key_event_ctrl_if bus();
    assign bus.evt_ready = ready;

    key_event_ctrl #(
        .DEB_CYC    (16),
        .LONG_CYC   (200),
        .DCLICK_CYC (80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_level (key_level),
        .evt       (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Cycle stamps: cyc counts rising edges; the monitor samples on falling edges.
    int   cyc = 0;
    int   fall_cyc = -1;
    int   rise_cyc = -1;
    int   evt_cyc = -1;
    int   n_evt = 0;
    int   valid_cycles = 0;
    logic [1:0] last_code = 2'd0;
    logic lvl_prev = 1'b1;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_level !== lvl_prev) begin
            if (key_level === 1'b0) fall_cyc = cyc;
            else                    rise_cyc = cyc;
        end
        lvl_prev = key_level;
        if (bus.evt_valid === 1'b1) begin
            valid_cycles++;
            if (valid_prev !== 1'b1) begin
                n_evt++;
                evt_cyc   = cyc;
                last_code = bus.evt_code;
            end
        end
        valid_prev = bus.evt_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    int t0;
    int base_evt;
    int base_vc;

    initial begin
        // Reset state
        rst = 1'b0; key = 1'b1; ready = 1'b1;
        tick(3);
        chk("rst_key_level", key_level, 1);
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_code", bus.evt_code, 0);
        chk("rst_overrun", bus.evt_overrun, 0);
        rst = 1'b1;
        tick(5);

        // Bounce rejection: 5-cycle toggles never reach the 16-cycle window
        base_evt = n_evt;
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(5);
        end
        chk("bounce_level_held", key_level, 1);
        key = 1'b0;
        t0 = cyc;
        tick(40);
        chk("bounce_fall_latency", fall_cyc - t0, 18);
        chk("bounce_no_event", n_evt - base_evt, 0);
        key = 1'b1;
        tick(150);

        // Single click
        base_evt = n_evt;
        base_vc  = valid_cycles;
        key = 1'b0; tick(50);
        key = 1'b1; tick(150);
        chk("single_count", n_evt - base_evt, 1);
        chk("single_code", last_code, 1);
        chk("single_latency", evt_cyc - rise_cyc, 81);
        chk("single_valid_cycles", valid_cycles - base_vc, 1);
        chk("single_code_idle", bus.evt_code, 0);

        // Double click
        base_evt = n_evt;
        key = 1'b0; tick(50);
        key = 1'b1; tick(40);
        key = 1'b0; tick(50);
        key = 1'b1; tick(150);
        chk("double_count", n_evt - base_evt, 1);
        chk("double_code", last_code, 2);
        chk("double_latency", evt_cyc - rise_cyc, 1);

        // Long press
        base_evt = n_evt;
        key = 1'b0; tick(500);
        chk("long_code", last_code, 3);
        chk("long_latency", evt_cyc - fall_cyc, 201);
        key = 1'b1; tick(150);
        chk("long_no_release_event", n_evt - base_evt, 1);

        // Overrun: SINGLE held while LONG arrives with no consumer
        ready = 1'b0;
        key = 1'b0; tick(50);
        key = 1'b1; tick(150);
        chk("ovr_single_valid", bus.evt_valid, 1);
        chk("ovr_single_code", bus.evt_code, 1);
        chk("ovr_not_yet", bus.evt_overrun, 0);
        key = 1'b0; tick(300);
        chk("ovr_flag", bus.evt_overrun, 1);
        chk("ovr_held_code", bus.evt_code, 1);
        key = 1'b1; tick(50);
        chk("ovr_still_valid", bus.evt_valid, 1);
        ready = 1'b1;
        tick(1);
        chk("ovr_taken_valid", bus.evt_valid, 0);
        chk("ovr_cleared", bus.evt_overrun, 0);
        chk("ovr_taken_code", bus.evt_code, 0);

        // Reset mid-gesture: held event plus a gesture in WAIT2
        ready = 1'b0;
        key = 1'b0; tick(50);
        key = 1'b1; tick(150);
        chk("rstmid_held", bus.evt_valid, 1);
        key = 1'b0; tick(50);
        key = 1'b1; tick(49);
        base_evt = n_evt;
        rst = 1'b0;
        #1;
        chk("rstmid_valid", bus.evt_valid, 0);
        chk("rstmid_code", bus.evt_code, 0);
        chk("rstmid_overrun", bus.evt_overrun, 0);
        chk("rstmid_key_level", key_level, 1);
        ready = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(150);
        chk("rstmid_no_single", n_evt - base_evt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
